axi_lite_reg_slave: RTL and testbench

AXI4-Lite responder exposing a four-register bank (CTRL, DATA, STATUS, ID) at a parameterised base address. Terminates one master port of the bus interconnect and is the endpoint the interconnect writes to and reads from. Write and read channels run independent handshake FSMs. Every transaction gets exactly one response: OKAY, or SLVERR for bad accesses.

---
 rtl/axi_lite_pkg.sv | 11 +
 rtl/axi_lite_regfile.sv | 58 +++++
 rtl/axi_lite_reg_slave.sv | 116 +++++++++++
 tb/tb_axi_lite_reg_slave.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared response codes, register offsets and FSM state types
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] OFF_CTRL = 4'h0;
  localparam logic [3:0] OFF_DATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_ID = 4'hC;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
endpackage

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: register storage, strobe merge, counters, decode and read mux
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strb,
  output logic [1:0]            wr_resp,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data,
  output logic [1:0]            rd_resp
);
  logic [31:0] ctrl_q, ctrl_d, data_q, data_d;
  logic [15:0] wr_ok_q, wr_ok_d, err_q, err_d;
  logic wr_err, rd_err;
  logic [1:0] err_inc;
  logic [16:0] err_sum;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int i = 0; i < 4; i++) merge[8*i+:8] = s[i] ? n[8*i+:8] : o[8*i+:8];
  endfunction
  always_comb begin
    wr_err = wr_addr[ADDR_WIDTH-1:4] != BASE_ADDR[ADDR_WIDTH-1:4] || wr_addr[1:0] != 2'b00 || wr_addr[3];
    rd_err = rd_addr[ADDR_WIDTH-1:4] != BASE_ADDR[ADDR_WIDTH-1:4] || rd_addr[1:0] != 2'b00;
    wr_resp = wr_err ? RESP_SLVERR : RESP_OKAY;
    rd_resp = rd_err ? RESP_SLVERR : RESP_OKAY;
    rd_data = rd_err ? '0 :
              rd_addr[3:0] == OFF_CTRL   ? ctrl_q :
              rd_addr[3:0] == OFF_DATA   ? data_q :
              rd_addr[3:0] == OFF_STATUS ? {err_q, wr_ok_q} : ID_VALUE;
    ctrl_d = (wr_en && !wr_err && wr_addr[3:0] == OFF_CTRL) ? merge(ctrl_q, wr_data, wr_strb) : ctrl_q;
    data_d = (wr_en && !wr_err && wr_addr[3:0] == OFF_DATA) ? merge(data_q, wr_data, wr_strb) : data_q;
    wr_ok_d = wr_ok_q + 16'(wr_en && !wr_err);
    err_inc = 2'(wr_en && wr_err) + 2'(rd_en && rd_err);
    err_sum = {1'b0, err_q} + 17'(err_inc);
    err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
      wr_ok_q <= '0;
      err_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      wr_ok_q <= wr_ok_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite responder with independent write and read handshake FSMs
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic awready_q, awready_d, wready_q, wready_d, aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic [1:0] wr_resp, rd_resp;
  axi_lite_regfile #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .ID_VALUE(ID_VALUE)) u_rf (
    .clk(s_axi_aclk), .rst(s_axi_areset),
    .wr_en(commit), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_resp(wr_resp),
    .rd_en(ar_hs), .rd_addr(s_axi_araddr), .rd_data(rd_data), .rd_resp(rd_resp)
  );
  always_comb begin
    aw_hs = s_axi_awvalid && awready_q;
    w_hs = s_axi_wvalid && wready_q;
    wr_addr = aw_held_q ? awaddr_q : s_axi_awaddr;
    wr_data = w_held_q ? wdata_q : s_axi_wdata;
    wr_strb = w_held_q ? wstrb_q : s_axi_wstrb;
    commit = w_state_q == W_IDLE && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    awaddr_d = aw_hs ? s_axi_awaddr : awaddr_q;
    wdata_d = w_hs ? s_axi_wdata : wdata_q;
    wstrb_d = w_hs ? s_axi_wstrb : wstrb_q;
    aw_held_d = !commit && (aw_held_q || aw_hs);
    w_held_d = !commit && (w_held_q || w_hs);
    w_state_d = commit ? W_RESP : (w_state_q == W_RESP && s_axi_bready) ? W_IDLE : w_state_q;
    bvalid_d = commit || (bvalid_q && !s_axi_bready);
    bresp_d = commit ? RESP_WIDTH'(wr_resp) : bresp_q;
    awready_d = w_state_d == W_IDLE && !aw_held_d;
    wready_d = w_state_d == W_IDLE && !w_held_d;
    ar_hs = s_axi_arvalid && arready_q;
    r_state_d = ar_hs ? R_DATA : (r_state_q == R_DATA && s_axi_rready) ? R_IDLE : r_state_q;
    rvalid_d = ar_hs || (rvalid_q && !s_axi_rready);
    rdata_d = ar_hs ? rd_data : rdata_q;
    rresp_d = ar_hs ? RESP_WIDTH'(rd_resp) : rresp_q;
    arready_d = r_state_d == R_IDLE;
  end
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      bvalid_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      bvalid_q <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end
  assign s_axi_awready = awready_q;
  assign s_axi_wready = wready_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: table-driven and directed checks of the AXI4-Lite register slave
module tb_axi_lite_reg_slave;
  logic clk = 0, rst = 1;
  logic [7:0] awaddr = 0, araddr = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [2:0] bresp, rresp;
  logic [31:0] rdata;
  int n_cmp = 0, n_fail = 0;
  int lat_a;
  logic [2:0] wr_r, rd_r;
  logic [31:0] rd_d;
  typedef struct {
    logic wr;
    logic [7:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [2:0] resp;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt[12];
  axi_lite_reg_slave dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [2:0] resp, output int lat);
    logic aw_go, w_go;
    awaddr = a;
    wdata = d;
    wstrb = s;
    awvalid = 1;
    wvalid = 1;
    lat = 0;
    while ((awvalid || wvalid) && lat < 20) begin
      aw_go = awready;
      w_go = wready;
      tick();
      lat++;
      if (aw_go) awvalid = 0;
      if (w_go) wvalid = 0;
    end
    for (int i = 0; i < 20 && !bvalid; i++) begin
      tick();
      lat++;
    end
    if (!bvalid) begin
      n_fail++;
      $display("FAIL wr_timeout: bvalid %b required 1", bvalid);
    end
    awvalid = 0;
    wvalid = 0;
    resp = bresp;
    bready = 1;
    tick();
    bready = 0;
  endtask
  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] resp);
    araddr = a;
    arvalid = 1;
    for (int i = 0; i < 20 && !arready; i++) tick();
    tick();
    arvalid = 0;
    if (!rvalid) begin
      n_fail++;
      $display("FAIL rd_timeout: rvalid %b required 1", rvalid);
    end
    d = rdata;
    resp = rresp;
    rready = 1;
    tick();
    rready = 0;
  endtask
  initial begin
    vt[0]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 4'hF, 3'd2, 32'h0};
    vt[1]  = '{1'b0, 8'h40, 32'h0, 4'h0, 3'd2, 32'h0};
    vt[2]  = '{1'b0, 8'h05, 32'h0, 4'h0, 3'd2, 32'h0};
    vt[3]  = '{1'b0, 8'h08, 32'h0, 4'h0, 3'd0, 32'h0003_0002};
    vt[4]  = '{1'b1, 8'h04, 32'hCAFE_F00D, 4'h0, 3'd0, 32'h0};
    vt[5]  = '{1'b0, 8'h04, 32'h0, 4'h0, 3'd0, 32'hDEAD_BEEF};
    vt[6]  = '{1'b1, 8'h04, 32'h0000_AB00, 4'b0010, 3'd0, 32'h0};
    vt[7]  = '{1'b0, 8'h04, 32'h0, 4'h0, 3'd0, 32'hDEAD_ABEF};
    vt[8]  = '{1'b1, 8'h0C, 32'h1234_5678, 4'hF, 3'd2, 32'h0};
    vt[9]  = '{1'b0, 8'h0C, 32'h0, 4'h0, 3'd0, 32'hA11E_0001};
    vt[10] = '{1'b0, 8'h08, 32'h0, 4'h0, 3'd0, 32'h0004_0004};
    vt[11] = '{1'b0, 8'h00, 32'h0, 4'h0, 3'd0, 32'h0022_0044};
    tick();
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    tick();
    rst = 0;
    tick();
    check("ready_aw", awready, 1);
    check("ready_w", wready, 1);
    check("ready_ar", arready, 1);
    axi_write(8'h04, 32'hDEAD_BEEF, 4'hF, wr_r, lat_a);
    check("wr1_latency", lat_a, 1);
    check("wr1_bresp", wr_r, 0);
    axi_read(8'h04, rd_d, rd_r);
    check("rd_data_val", rd_d, 32'hDEAD_BEEF);
    check("rd_data_resp", rd_r, 0);
    axi_read(8'h08, rd_d, rd_r);
    check("status_one", rd_d, 32'h0000_0001);
    awaddr = 8'h00;
    wdata = 32'h1122_3344;
    wstrb = 4'b0101;
    wvalid = 1;
    tick();
    wvalid = 0;
    check("split_wready_low", wready, 0);
    check("split_no_bvalid0", bvalid, 0);
    tick();
    check("split_no_bvalid1", bvalid, 0);
    awvalid = 1;
    tick();
    awvalid = 0;
    check("split_bvalid", bvalid, 1);
    check("split_bresp", bresp, 0);
    bready = 1;
    tick();
    bready = 0;
    check("split_bvalid_drop", bvalid, 0);
    tick();
    check("split_single_pulse", bvalid, 0);
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, wr_r, lat_a);
        check($sformatf("vec%0d_bresp", i), wr_r, vt[i].resp);
      end else begin
        axi_read(vt[i].addr, rd_d, rd_r);
        check($sformatf("vec%0d_rresp", i), rd_r, vt[i].resp);
        check($sformatf("vec%0d_rdata", i), rd_d, vt[i].rdata);
      end
    end
    awaddr = 8'h00;
    wdata = 32'h1;
    wstrb = 4'hF;
    awvalid = 1;
    wvalid = 1;
    tick();
    awaddr = 8'h04;
    wdata = 32'h55;
    wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check("hold_bvalid", bvalid, 1);
      check("hold_bresp", bresp, 0);
      check("hold_awready", awready, 0);
      check("hold_wready", wready, 0);
      tick();
    end
    awvalid = 0;
    bready = 1;
    tick();
    bready = 0;
    check("hold_release", bvalid, 0);
    axi_read(8'h04, rd_d, rd_r);
    check("hold_no_extra_write", rd_d, 32'hDEAD_ABEF);
    axi_read(8'h00, rd_d, rd_r);
    check("hold_ctrl", rd_d, 32'h1);
    fork
      axi_write(8'h04, 32'h1234_5678, 4'hF, wr_r, lat_a);
      axi_read(8'h04, rd_d, rd_r);
    join
    check("same_cyc_prewrite", rd_d, 32'hDEAD_ABEF);
    check("same_cyc_bresp", wr_r, 0);
    axi_read(8'h04, rd_d, rd_r);
    check("same_cyc_postwrite", rd_d, 32'h1234_5678);
    fork
      axi_write(8'h00, 32'h2, 4'hF, wr_r, lat_a);
      axi_read(8'h08, rd_d, rd_r);
    join
    check("status_pre_incr", rd_d, 32'h0004_0006);
    axi_read(8'h08, rd_d, rd_r);
    check("status_post_incr", rd_d, 32'h0004_0007);
    force dut.u_rf.wr_ok_q = 16'hFFFF;
    force dut.u_rf.err_q = 16'hFFFE;
    tick();
    release dut.u_rf.wr_ok_q;
    release dut.u_rf.err_q;
    axi_write(8'h00, 32'h3, 4'hF, wr_r, lat_a);
    axi_read(8'h08, rd_d, rd_r);
    check("wr_ok_wrap", rd_d, 32'hFFFE_0000);
    fork
      axi_write(8'h08, 32'h0, 4'hF, wr_r, lat_a);
      axi_read(8'h41, rd_d, rd_r);
    join
    check("dual_err_bresp", wr_r, 2);
    check("dual_err_rresp", rd_r, 2);
    check("dual_err_rdata", rd_d, 0);
    axi_read(8'h08, rd_d, rd_r);
    check("err_sat_dual", rd_d, 32'hFFFF_0000);
    axi_read(8'h80, rd_d, rd_r);
    axi_read(8'h08, rd_d, rd_r);
    check("err_sat_hold", rd_d, 32'hFFFF_0000);
    awaddr = 8'h04;
    wdata = 32'h99;
    wstrb = 4'hF;
    awvalid = 1;
    wvalid = 1;
    tick();
    awvalid = 0;
    wvalid = 0;
    check("mid_bvalid", bvalid, 1);
    rst = 1;
    tick();
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_awready", awready, 0);
    rst = 0;
    tick();
    check("mid_post_awready", awready, 1);
    check("mid_post_bvalid", bvalid, 0);
    axi_read(8'h04, rd_d, rd_r);
    check("mid_data_zero", rd_d, 0);
    axi_read(8'h08, rd_d, rd_r);
    check("mid_status_zero", rd_d, 0);
    axi_read(8'h0C, rd_d, rd_r);
    check("mid_id", rd_d, 32'hA11E_0001);
    axi_read(8'h00, rd_d, rd_r);
    check("mid_ctrl_zero", rd_d, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
